// File: rtl/vpu_issue_tracker.sv
// vpu_issue_tracker
//   Tracks up to DEPTH in-flight vector ops, each with its own execution
//   latency, and releases their completions strictly in issue order.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst_n          : synchronous active-low reset
//   issue_valid_i  : an op is offered for issue
//   issue_ready_o  : tracker can accept an op this cycle (count < DEPTH)
//   issue_delay_i  : execution latency of the offered op in cycles (0 acts as 1)
//   issue_tag_i    : tag of the offered op
//   done_valid_o   : oldest op has finished its latency
//   done_ready_i   : consumer accepts the completion
//   done_tag_o     : tag of the completing op
//   busy_o         : at least one op is outstanding
//   count_o        : number of outstanding ops
module vpu_issue_tracker #(
  parameter int DEPTH   = 4,
  parameter int DELAY_W = 4,
  parameter int TAG_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [DELAY_W-1:0]           issue_delay_i,
  input  logic [TAG_W-1:0]             issue_tag_i,
  output logic                         done_valid_o,
  input  logic                         done_ready_i,
  output logic [TAG_W-1:0]             done_tag_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic               valid_q [DEPTH];
  logic [TAG_W-1:0]   tag_q   [DEPTH];
  logic [DELAY_W-1:0] rem_q   [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               retire;
  logic [DELAY_W-1:0] load_val;

  // Ready depends only on registered count, so a retire in the same cycle
  // never opens a slot for a full tracker.
  assign issue_ready_o = (count_q < DEPTH_C);
  assign done_valid_o  = valid_q[rd_ptr_q] && (rem_q[rd_ptr_q] == '0);
  assign done_tag_o    = tag_q[rd_ptr_q];
  assign busy_o        = (state_q != S_IDLE);
  assign count_o       = count_q;

  assign accept = issue_valid_i && issue_ready_o;
  assign retire = done_valid_o && done_ready_i;

  // Remaining cycles after the accept edge; a zero delay behaves as one.
  assign load_val = (issue_delay_i == '0) ? '0 : issue_delay_i - DELAY_W'(1);

  // Per-entry storage. Slots are exclusive between load and retire: the
  // write slot equals the read slot only when empty (no retire) or full
  // (no accept).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[gi] <= 1'b0;
        tag_q[gi]   <= '0;
        rem_q[gi]   <= '0;
      end else if (accept && (wr_ptr_q == PTR_W'(gi))) begin
        valid_q[gi] <= 1'b1;
        tag_q[gi]   <= issue_tag_i;
        rem_q[gi]   <= load_val;
      end else if (retire && (rd_ptr_q == PTR_W'(gi))) begin
        valid_q[gi] <= 1'b0;
      end else if (valid_q[gi] && (rem_q[gi] != '0)) begin
        // Saturating countdown: a ripe entry just waits at zero.
        rem_q[gi] <= rem_q[gi] - DELAY_W'(1);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (accept && !retire) count_d = count_q + ONE_C;
    else if (retire && !accept) count_d = count_q - ONE_C;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (retire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && !retire && (count_q == DEPTH_C - ONE_C)) state_d = S_FULL;
        else if (retire && !accept && (count_q == ONE_C)) state_d = S_IDLE;
      end
      S_FULL: begin
        if (retire) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vpu_issue_tracker.sv
// Directed testbench for vpu_issue_tracker with default parameters.
module tb_vpu_issue_tracker;

  localparam int DEPTH   = 4;
  localparam int DELAY_W = 4;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               rst_n;
  logic               issue_valid;
  logic               issue_ready;
  logic [DELAY_W-1:0] issue_delay;
  logic [TAG_W-1:0]   issue_tag;
  logic               done_valid;
  logic               done_ready;
  logic [TAG_W-1:0]   done_tag;
  logic               busy;
  logic [CNT_W-1:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  vpu_issue_tracker #(.DEPTH(DEPTH), .DELAY_W(DELAY_W), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready),
    .issue_delay_i (issue_delay),
    .issue_tag_i   (issue_tag),
    .done_valid_o  (done_valid),
    .done_ready_i  (done_ready),
    .done_tag_o    (done_tag),
    .busy_o        (busy),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int tag, input int dly);
    issue_valid = 1'b1;
    issue_tag   = TAG_W'(tag);
    issue_delay = DELAY_W'(dly);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 1'b0; issue_delay = '0; issue_tag = '0; done_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++; if (done_tag !== 5'd0) begin tests_failed++; $display("FAIL reset_done_tag: got %0d want 0", done_tag); end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_op();
    done_ready = 1'b1;
    issue(5, 3);  // edge 0
    tests_run++; if (done_valid !== 1'b0 || count !== 3'd1 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL single_after_e0: got v=%b c=%0d b=%b want v=0 c=1 b=1", done_valid, count, busy); end
    tick();       // edge 1
    tests_run++; if (done_valid !== 1'b0) begin tests_failed++; $display("FAIL single_after_e1: got v=%b want 0", done_valid); end
    tick();       // edge 2
    tests_run++; if (done_valid !== 1'b1 || done_tag !== 5'd5) begin
      tests_failed++; $display("FAIL single_after_e2: got v=%b tag=%0d want v=1 tag=5", done_valid, done_tag); end
    tick();       // edge 3 retires
    tests_run++; if (done_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_after_retire: got v=%b c=%0d b=%b want 0 0 0", done_valid, count, busy); end
    $display("[TB] single op tag 5 delay 3 checked");
  endtask

  task automatic test_out_of_order();
    int early;
    done_ready = 1'b1;
    issue(1, 8);  // edge 0
    issue(2, 1);  // edge 1
    early = 0;
    if (done_valid) early++;
    for (int e = 2; e <= 6; e++) begin
      tick();
      if (done_valid) early++;
    end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL ooo_held: got %0d early completions want 0", early); end
    tick();       // edge 7
    tests_run++; if (done_valid !== 1'b1 || done_tag !== 5'd1) begin
      tests_failed++; $display("FAIL ooo_first: got v=%b tag=%0d want v=1 tag=1", done_valid, done_tag); end
    tick();       // edge 8
    tests_run++; if (done_valid !== 1'b1 || done_tag !== 5'd2) begin
      tests_failed++; $display("FAIL ooo_second: got v=%b tag=%0d want v=1 tag=2", done_valid, done_tag); end
    tick();       // edge 9
    tests_run++; if (done_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL ooo_empty: got v=%b c=%0d want 0 0", done_valid, count); end
    $display("[TB] out-of-order ripening checked");
  endtask

  task automatic test_full();
    done_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(10 + i, 1);
    tests_run++; if (issue_ready !== 1'b0 || count !== 3'd4 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL full_state: got r=%b c=%0d b=%b want r=0 c=4 b=1", issue_ready, count, busy); end
    issue_valid = 1'b1; issue_tag = 5'd14; issue_delay = 4'd1;
    tick();
    tests_run++; if (count !== 3'd4 || done_tag !== 5'd10) begin
      tests_failed++; $display("FAIL full_fifth_rejected: got c=%0d tag=%0d want c=4 tag=10", count, done_tag); end
    done_ready = 1'b1;  // retire with an offer pending: no pass-through
    tick();
    issue_valid = 1'b0;
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL full_no_passthrough: got c=%0d want 3", count); end
    for (int i = 1; i < 4; i++) begin
      tests_run++; if (done_valid !== 1'b1 || done_tag !== TAG_W'(10 + i)) begin
        tests_failed++; $display("FAIL full_drain_%0d: got v=%b tag=%0d want v=1 tag=%0d", i, done_valid, done_tag, 10 + i); end
      tick();
    end
    tests_run++; if (count !== 3'd0 || done_valid !== 1'b0) begin
      tests_failed++; $display("FAIL full_drained: got c=%0d v=%b want 0 0", count, done_valid); end
    $display("[TB] full/backpressure checked");
  endtask

  task automatic test_simultaneous();
    int got_q[$];
    int cyc;
    done_ready = 1'b1;
    issue(20, 2);  // edge 0
    issue(21, 2);  // edge 1: tag 20 ripe
    tests_run++; if (count !== 3'd2 || done_valid !== 1'b1 || done_tag !== 5'd20) begin
      tests_failed++; $display("FAIL simul_pre: got c=%0d v=%b tag=%0d want c=2 v=1 tag=20", count, done_valid, done_tag); end
    got_q.push_back(20);
    issue(22, 5);  // edge 2: retire 20 and accept 22
    tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL simul_count: got c=%0d want 2", count); end
    cyc = 0;
    while (count != 0 && cyc < 20) begin
      if (done_valid) got_q.push_back(int'(done_tag));
      tick(); cyc++;
    end
    tests_run++; if (got_q.size() != 3 || got_q[1] != 21 || got_q[2] != 22) begin
      tests_failed++; $display("FAIL simul_order: got %0d retires want 3 (20,21,22)", got_q.size()); end
    $display("[TB] simultaneous accept/retire checked");
  endtask

  task automatic test_back_to_back();
    int got_q[$];
    int next_i, cyc, bad;
    logic acc;
    done_ready = 1'b1;
    next_i = 0; cyc = 0;
    while (got_q.size() < 10 && cyc < 80) begin
      issue_valid = (next_i < 10);
      issue_tag   = TAG_W'(30 + (next_i % 2));
      issue_tag   = TAG_W'(next_i + 3);
      issue_delay = DELAY_W'((next_i % 3) + 1);
      if (done_valid) got_q.push_back(int'(done_tag));
      acc = issue_valid && issue_ready;
      tick(); cyc++;
      if (acc) next_i++;
    end
    issue_valid = 1'b0;
    tests_run++; if (got_q.size() != 10) begin tests_failed++; $display("FAIL b2b_count: got %0d retires want 10", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] != i + 3) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL b2b_order: got %0d out-of-order tags want 0", bad); end
    tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL b2b_empty: got c=%0d want 0", count); end
    $display("[TB] 10 back-to-back ops with pointer wrap checked");
  endtask

  task automatic test_delay_bounds();
    int lat;
    done_ready = 1'b0;
    issue(7, 0);
    tests_run++; if (done_valid !== 1'b1 || done_tag !== 5'd7) begin
      tests_failed++; $display("FAIL delay0_ripe: got v=%b tag=%0d want v=1 tag=7", done_valid, done_tag); end
    tick(); tick(); tick();
    tests_run++; if (done_valid !== 1'b1 || done_tag !== 5'd7) begin
      tests_failed++; $display("FAIL delay0_hold: got v=%b tag=%0d want v=1 tag=7", done_valid, done_tag); end
    done_ready = 1'b1;
    tick();
    tests_run++; if (done_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL delay0_retire: got v=%b c=%0d want 0 0", done_valid, count); end
    issue(9, 15);
    lat = 1;
    while (!done_valid && lat < 40) begin tick(); lat++; end
    tests_run++; if (lat != 15 || done_tag !== 5'd9) begin
      tests_failed++; $display("FAIL delay15_latency: got lat=%0d tag=%0d want lat=15 tag=9", lat, done_tag); end
    tick();
    tests_run++; if (done_valid !== 1'b0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL delay15_retire: got v=%b c=%0d want 0 0", done_valid, count); end
    $display("[TB] delay 0 and delay 15 checked");
  endtask

  task automatic test_reset_mid();
    int stale;
    done_ready = 1'b0;
    issue(1, 1); issue(2, 1); issue(3, 1);
    tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL rstmid_pre: got c=%0d want 3", count); end
    rst_n = 1'b0;
    issue_valid = 1'b1; issue_tag = 5'd4; issue_delay = 4'd1;
    tick();
    tests_run++; if (count !== 3'd0 || done_valid !== 1'b0 || issue_ready !== 1'b1 || busy !== 1'b0 || done_tag !== 5'd0) begin
      tests_failed++; $display("FAIL rstmid_cleared: got c=%0d v=%b r=%b b=%b tag=%0d want 0 0 1 0 0", count, done_valid, issue_ready, busy, done_tag); end
    rst_n = 1'b1; issue_valid = 1'b0; done_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_valid) stale++;
    end
    tests_run++; if (stale != 0 || count !== 3'd0) begin
      tests_failed++; $display("FAIL rstmid_stale: got %0d completions c=%0d want 0 0", stale, count); end
    $display("[TB] reset mid-operation checked");
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_out_of_order();
    test_full();
    test_simultaneous();
    test_back_to_back();
    test_delay_bounds();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vpu_issue_tracker.md
VPU_ISSUE_TRACKER -- requirements
Module: vpu_issue_tracker

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding ops; power of two, >= 2.
REQ-002 Parameter DELAY_W, default 4: width of the per-op latency field.
REQ-003 Parameter TAG_W, default 5: width of the op tag.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 Port issue_valid_i, input, 1: an op is offered for issue.
REQ-007 Port issue_ready_o, output, 1: tracker can accept an op this cycle.
REQ-008 Port issue_delay_i, input, DELAY_W: execution latency of the offered op, in cycles.
REQ-009 Port issue_tag_i, input, TAG_W: tag of the offered op.
REQ-010 Port done_valid_o, output, 1: the oldest op has completed its latency.
REQ-011 Port done_ready_i, input, 1: consumer accepts the completion.
REQ-012 Port done_tag_o, output, TAG_W: tag of the completing op.
REQ-013 Port busy_o, output, 1: at least one op is outstanding.
REQ-014 Port count_o, output, $clog2(DEPTH+1): number of outstanding ops.

Function
REQ-015 Issue handshake: an op is accepted on a rising edge where issue_valid_i && issue_ready_o.
REQ-016 Done handshake: an op retires on a rising edge where done_valid_o && done_ready_i.
REQ-017 Entry storage: circular queue of DEPTH entries, each holding {valid, tag, remaining counter (DELAY_W bits)}, with wr_ptr and rd_ptr wrapping modulo DEPTH.
REQ-018 Counter load on accept: remaining = issue_delay_i - 1; issue_delay_i == 0 is treated as 1 (remaining = 0).
REQ-019 Counter update: every valid entry with remaining > 0 decrements by 1 each cycle after its accept edge; it saturates at 0 and never wraps.
REQ-020 Latency: an op accepted at edge k with delay D >= 1 drives done_valid_o high from the cycle following edge k+D-1 (D=1: the cycle right after acceptance), provided it is at the head.
REQ-021 Ordering: completion is strictly in issue order; a younger op that ripens first waits until all older ops retire.
REQ-022 done_valid_o = head entry valid && head remaining == 0; done_tag_o = head tag (don't-care when done_valid_o is low).
REQ-023 Once asserted, done_valid_o and done_tag_o hold stable until the retire handshake.
REQ-024 issue_ready_o = (count < DEPTH); there is no same-cycle pass-through when full, even if a retire occurs.
REQ-025 Simultaneous accept and retire: count unchanged; both pointers advance; the new entry loads normally.
REQ-026 FSM states, registered: S_IDLE (count 0), S_RUN (0 < count < DEPTH), S_FULL (count == DEPTH); next state follows the next count.
REQ-027 FSM transitions: IDLE->RUN on accept; RUN->FULL on accept without retire at count DEPTH-1; FULL->RUN on retire; RUN->IDLE on retire without accept at count 1; all other cases hold.
REQ-028 busy_o = (state != S_IDLE); count_o equals the registered count.
REQ-029 Pointer wrap: after DEPTH accepts, wr_ptr returns to 0; ordering is preserved across the wrap.
REQ-030 Outputs are driven from registered state only; there is no combinational path from issue_* to done_*.

Reset
REQ-031 While rst_n is low at a rising edge: all entry valid bits, counters, wr_ptr, rd_ptr and count clear to 0, and the state becomes S_IDLE.
REQ-032 Post-reset output values: issue_ready_o=1, done_valid_o=0, busy_o=0, count_o=0, done_tag_o=0.
REQ-033 Reset mid-operation discards all outstanding ops with no done_valid_o pulse; an issue offered in the reset cycle is not accepted.

Verification
REQ-034 Single op: issue tag 5, delay 3 at edge 0, done_ready_i=1 -> done_valid_o high only in the cycle after edge 2 with done_tag_o=5; count_o returns 0; busy_o falls.
REQ-035 Out-of-order ripening: issue tag 1 with delay 8, then tag 2 with delay 1 -> tag 2 is held; tag 1 retires after 8 cycles, then tag 2 on the next cycle.
REQ-036 Full/backpressure: done_ready_i=0, issue 4 ops with delay 1 -> issue_ready_o=0 and count_o=4 in state FULL; a fifth offer is not accepted; release done_ready_i -> tags drain in order at one per cycle.
REQ-037 Simultaneous accept and retire at count 2 -> count_o stays 2; 10 back-to-back ops wrap the pointers and retire in order.
REQ-038 Delay 0 -> same behaviour as delay 1; delay 15 -> exactly 15-cycle latency, with no counter underflow.
REQ-039 Assert rst_n=0 with 3 ops outstanding -> next cycle count_o=0, done_valid_o=0, issue_ready_o=1; no stale completion appears.
